// File: rtl/demux_1_2_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : demux_1_2_reg_if
// Description : Bus bundle for the registered 1-to-2 demultiplexer. Carries
//               the producer-side handshake, both consumer channels and the
//               per-channel transfer counters.
// Revision    : 1.0 - initial release
// ============================================================================
interface demux_1_2_reg_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             sel;
    logic             in_ready;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic             out1_valid;
    logic             out2_valid;
    logic             out1_ready;
    logic             out2_ready;
    logic [31:0]      count1;
    logic [31:0]      count2;

    // Producer and consumers drive this side
    modport master (
        output in, in_valid, sel, out1_ready, out2_ready,
        input  in_ready, out1, out2, out1_valid, out2_valid, count1, count2
    );

    // The demultiplexer itself
    modport slave (
        input  in, in_valid, sel, out1_ready, out2_ready,
        output in_ready, out1, out2, out1_valid, out2_valid, count1, count2
    );
endinterface
`default_nettype wire

// File: rtl/demux_1_2_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux_1_2_reg
// Description : Registered 1-to-2 demultiplexer. One valid/ready input word
//               per cycle is steered by sel into one of two independent
//               2-entry FIFOs. Outputs other than in_ready are registers.
//               Optional per-channel pop counters are built when the macro
//               DEMUX_1_2_STATS_EN is defined; otherwise counts read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1_2_reg #(
    parameter int WIDTH = 32
) (
    input  wire               clk,
    input  wire               rst_n,
    demux_1_2_reg_if.slave    bus
);

    logic [1:0]             full;
    logic [1:0]             push;
    logic [1:0]             cons_ready;
    logic [1:0][WIDTH-1:0]  head;
    logic [1:0]             head_valid;
    logic [1:0][31:0]       cnt;
    logic                   w_in_ready;
    logic                   w_accept;

    // in_ready looks only at sel and registered occupancy, never at the
    // consumer ready inputs, so a pop cannot free space in the same cycle.
    assign w_in_ready = bus.sel ? ~full[1] : ~full[0];
    assign w_accept   = bus.in_valid & w_in_ready;
    assign push[0]    = w_accept & ~bus.sel;
    assign push[1]    = w_accept &  bus.sel;
    assign cons_ready = {bus.out2_ready, bus.out1_ready};

    for (genvar k = 0; k < 2; k++) begin : g_ch
        logic [1:0]       r_occ;
        logic             r_rd;
        logic             r_wr;
        logic [WIDTH-1:0] r_mem [2];
        logic [WIDTH-1:0] r_out;
        logic             r_valid;
        logic             w_pop;
        logic [1:0]       w_occ_nxt;
        logic [WIDTH-1:0] w_head_nxt;

        // r_valid mirrors (r_occ != 0), so it can qualify the pop directly
        assign w_pop     = r_valid & cons_ready[k];
        assign w_occ_nxt = r_occ + {1'b0, push[k]} - {1'b0, w_pop};

        // Next head word: zero when the channel drains, the incoming word
        // when it becomes the only entry, else the older second entry on pop.
        always_comb begin
            w_head_nxt = r_out;
            if (w_occ_nxt == 2'd0) begin
                w_head_nxt = '0;
            end else if ((r_occ == 2'd0) || (w_pop && (r_occ == 2'd1))) begin
                w_head_nxt = bus.in;
            end else if (w_pop) begin
                w_head_nxt = r_mem[~r_rd];
            end
        end

        // Occupancy, pointers and registered head/valid outputs
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_occ   <= 2'd0;
                r_rd    <= 1'b0;
                r_wr    <= 1'b0;
                r_out   <= '0;
                r_valid <= 1'b0;
            end else begin
                r_occ   <= w_occ_nxt;
                r_rd    <= r_rd ^ w_pop;
                r_wr    <= r_wr ^ push[k];
                r_out   <= w_head_nxt;
                r_valid <= (w_occ_nxt != 2'd0);
            end
        end

        // Storage array; contents are don't-care while unoccupied
        always_ff @(posedge clk) begin
            if (rst_n && push[k]) begin
                r_mem[r_wr] <= bus.in;
            end
        end

        assign full[k]       = (r_occ == 2'd2);
        assign head[k]       = r_out;
        assign head_valid[k] = r_valid;

`ifdef DEMUX_1_2_STATS_EN
        logic [31:0] r_cnt;

        // Completed-transfer counter, wraps naturally at 2^32
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cnt <= 32'd0;
            end else if (w_pop) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end

        assign cnt[k] = r_cnt;
`else
        assign cnt[k] = 32'd0;
`endif
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out1       = head[0];
    assign bus.out2       = head[1];
    assign bus.out1_valid = head_valid[0];
    assign bus.out2_valid = head_valid[1];
    assign bus.count1     = cnt[0];
    assign bus.count2     = cnt[1];

endmodule
`default_nettype wire

// File: tb/tb_demux_1_2_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1_2_reg
// Description : Self-checking bench for demux_1_2_reg: directed vector table,
//               reset-while-full sequence and randomized traffic against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1_2_reg;
    localparam int WIDTH = 32;
`ifdef DEMUX_1_2_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux_1_2_reg_if #(.WIDTH(WIDTH)) bus ();

    demux_1_2_reg #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference model: one queue per channel plus pop counters
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic [31:0] mc1 = 0;
    logic [31:0] mc2 = 0;

    // Transition decided at negedge, applied after the rising edge
    bit t_rst, t_pop1, t_pop2, t_push1, t_push2;
    logic [31:0] t_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_ready();
        return bus.sel ? (q2.size() < 2) : (q1.size() < 2);
    endfunction

    task automatic check_model();
        chk("in_ready",   {31'd0, bus.in_ready},   {31'd0, m_ready()});
        chk("out1_valid", {31'd0, bus.out1_valid}, {31'd0, q1.size() != 0});
        chk("out2_valid", {31'd0, bus.out2_valid}, {31'd0, q2.size() != 0});
        chk("out1",       bus.out1, (q1.size() != 0) ? q1[0] : 32'd0);
        chk("out2",       bus.out2, (q2.size() != 0) ? q2[0] : 32'd0);
        chk("count1",     bus.count1, STATS ? mc1 : 32'd0);
        chk("count2",     bus.count2, STATS ? mc2 : 32'd0);
    endtask

    // Drive one cycle's inputs, then at negedge check and plan the model step
    task automatic cycle_begin(input logic rn, input logic iv, input logic s,
                               input logic [31:0] d, input logic r1, input logic r2);
        logic acc;
        rst_n          = rn;
        bus.in_valid   = iv;
        bus.sel        = s;
        bus.in         = d;
        bus.out1_ready = r1;
        bus.out2_ready = r2;
        @(negedge clk);
        if (chk_en) check_model();
        acc     = iv && m_ready();
        t_rst   = !rn;
        t_pop1  = r1 && (q1.size() != 0);
        t_pop2  = r2 && (q2.size() != 0);
        t_push1 = acc && !s;
        t_push2 = acc && s;
        t_data  = d;
    endtask

    task automatic cycle_end();
        @(posedge clk);
        #1;
        if (t_rst) begin
            q1.delete();
            q2.delete();
            mc1 = 0;
            mc2 = 0;
        end else begin
            if (t_pop1) begin void'(q1.pop_front()); mc1++; end
            if (t_pop2) begin void'(q2.pop_front()); mc2++; end
            if (t_push1) q1.push_back(t_data);
            if (t_push2) q2.push_back(t_data);
        end
    endtask

    typedef struct {
        logic        iv;
        logic        s;
        logic [31:0] d;
        logic        r1;
        logic        r2;
        logic        e_rdy;
        logic        e_v1;
        logic [31:0] e_o1;
        logic        e_v2;
        logic [31:0] e_o2;
        logic [31:0] c1;
        logic [31:0] c2;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // Expected values are the outputs seen during the cycle the vector is driven
        tbl[0]  = '{1, 0, 17, 0, 0,  1, 0,  0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0,  0, 0, 0,  1, 1, 17, 0, 0, 0, 0};
        tbl[2]  = '{1, 1,  6, 0, 1,  1, 1, 17, 0, 0, 0, 0};
        tbl[3]  = '{0, 1,  0, 0, 1,  1, 1, 17, 1, 6, 0, 0};
        tbl[4]  = '{0, 0,  0, 0, 1,  1, 1, 17, 0, 0, 0, 1};
        tbl[5]  = '{0, 0,  0, 1, 0,  1, 1, 17, 0, 0, 0, 1};
        tbl[6]  = '{1, 0,  1, 0, 0,  1, 0,  0, 0, 0, 1, 1};
        tbl[7]  = '{1, 0,  2, 0, 0,  1, 1,  1, 0, 0, 1, 1};
        tbl[8]  = '{1, 0,  3, 0, 0,  0, 1,  1, 0, 0, 1, 1};
        tbl[9]  = '{1, 1,  3, 0, 0,  1, 1,  1, 0, 0, 1, 1};
        tbl[10] = '{1, 0,  4, 1, 0,  0, 1,  1, 1, 3, 1, 1};
        tbl[11] = '{1, 0,  4, 0, 0,  1, 1,  2, 1, 3, 2, 1};
        tbl[12] = '{0, 0,  0, 1, 0,  0, 1,  2, 1, 3, 2, 1};
        tbl[13] = '{0, 0,  0, 1, 0,  1, 1,  4, 1, 3, 3, 1};
        tbl[14] = '{0, 0,  0, 0, 1,  1, 0,  0, 1, 3, 4, 1};
        tbl[15] = '{0, 1,  0, 0, 0,  1, 0,  0, 0, 0, 4, 2};

        // Reset: first cycle outputs are undefined, second shows reset values
        cycle_begin(0, 0, 0, 0, 0, 0); cycle_end();
        chk_en = 1'b1;
        cycle_begin(0, 0, 1, 0, 0, 0); cycle_end();

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            cycle_begin(1, tbl[i].iv, tbl[i].s, tbl[i].d, tbl[i].r1, tbl[i].r2);
            chk($sformatf("v%0d in_ready", i),   {31'd0, bus.in_ready},   {31'd0, tbl[i].e_rdy});
            chk($sformatf("v%0d out1_valid", i), {31'd0, bus.out1_valid}, {31'd0, tbl[i].e_v1});
            chk($sformatf("v%0d out1", i),       bus.out1, tbl[i].e_o1);
            chk($sformatf("v%0d out2_valid", i), {31'd0, bus.out2_valid}, {31'd0, tbl[i].e_v2});
            chk($sformatf("v%0d out2", i),       bus.out2, tbl[i].e_o2);
            chk($sformatf("v%0d count1", i),     bus.count1, STATS ? tbl[i].c1 : 32'd0);
            chk($sformatf("v%0d count2", i),     bus.count2, STATS ? tbl[i].c2 : 32'd0);
            cycle_end();
        end

        // Fill both channels, then reset with consumers ready: nothing pops
        cycle_begin(1, 1, 0, 5, 0, 0); cycle_end();
        cycle_begin(1, 1, 1, 7, 0, 0); cycle_end();
        cycle_begin(1, 1, 0, 8, 0, 0); cycle_end();
        cycle_begin(1, 1, 1, 9, 0, 0); cycle_end();
        cycle_begin(0, 1, 0, 10, 1, 1);
        chk("full in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("full out1", bus.out1, 32'd5);
        cycle_end();
        cycle_begin(1, 0, 0, 0, 0, 0);
        chk("rst out1_valid", {31'd0, bus.out1_valid}, 32'd0);
        chk("rst out2_valid", {31'd0, bus.out2_valid}, 32'd0);
        chk("rst out1", bus.out1, 32'd0);
        chk("rst out2", bus.out2, 32'd0);
        chk("rst in_ready sel0", {31'd0, bus.in_ready}, 32'd1);
        chk("rst count1", bus.count1, 32'd0);
        cycle_end();
        cycle_begin(1, 0, 1, 0, 0, 0);
        chk("rst in_ready sel1", {31'd0, bus.in_ready}, 32'd1);
        cycle_end();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            cycle_begin(($urandom_range(0, 199) != 0),
                        ($urandom_range(0, 3) != 0),
                        1'($urandom),
                        $urandom,
                        ($urandom_range(0, 2) != 0),
                        ($urandom_range(0, 3) == 0));
            cycle_end();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
